// File: rtl/lbp_param.sv
// lbp_param: raster-order 3x3 local binary pattern engine with optional threshold.
// Gray reads are stalled by gray_ready; border pixels are written as zero without reads.
module lbp_param #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    input  logic [DATA_W-1:0] gray_data,
    input  logic              mode,
    input  logic [DATA_W-1:0] thr,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic [7:0]        lbp_data,
    output logic              finish
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef enum logic [2:0] {IDLE, BORDER, FILL, SHIFT, WRITE, DONE} state_t;
    state_t            r_state;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [3:0]        r_cnt;
    logic              r_mode;
    logic [DATA_W-1:0] r_thr;
    logic [DATA_W-1:0] r_win [9];
    logic              w_border, w_last, w_read;
    logic [1:0]        w_dr, w_dc;
    logic [3:0]        w_wi;
    logic [RW-1:0]     w_rr;
    logic [CW-1:0]     w_cc;
    logic [DATA_W:0]   w_ref;
    logic [7:0]        w_code;
    always_comb begin
        w_border = r_row == '0 || r_row == RW'(IMG_H-1) || r_col == '0 || r_col == CW'(IMG_W-1);
        w_last   = r_row == RW'(IMG_H-1) && r_col == CW'(IMG_W-1);
        w_read   = r_state == FILL || r_state == SHIFT;
        // FILL walks the whole window; SHIFT only the new right column
        w_dr     = r_state == FILL ? (r_cnt >= 4'd6 ? 2'd2 : r_cnt >= 4'd3 ? 2'd1 : 2'd0) : r_cnt[1:0];
        w_dc     = r_state == FILL ? 2'(r_cnt - {1'b0, w_dr, 1'b0} - {2'b0, w_dr}) : 2'd2;
        w_wi     = {1'b0, w_dr, 1'b0} + {2'b0, w_dr} + {2'b0, w_dc};
        w_rr     = r_row - RW'(1) + RW'(w_dr);
        w_cc     = r_col - CW'(1) + CW'(w_dc);
        w_ref    = r_mode ? {1'b0, r_win[4]} + {1'b0, r_thr} : {1'b0, r_win[4]};
        w_code   = '0;
        for (int i = 0; i < 8; i++)
            w_code[i] = {1'b0, r_win[i < 4 ? i : i + 1]} >= w_ref;
    end
    assign gray_addr = w_read ? ADDR_W'({w_rr, w_cc}) : '0;
    assign gray_req  = w_read & gray_ready & ~reset;
    assign lbp_addr  = ADDR_W'({r_row, r_col});
    assign lbp_valid = ((r_state == BORDER && w_border) || r_state == WRITE) && !reset;
    assign lbp_data  = r_state == WRITE ? w_code : 8'd0;
    assign finish    = r_state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_thr   <= '0;
        end else begin
            case (r_state)
                IDLE: if (gray_ready) begin
                    r_mode  <= mode;
                    r_thr   <= thr;
                    r_state <= BORDER;
                end
                BORDER: if (w_border) begin
                    r_col   <= r_col + CW'(1);
                    if (r_col == CW'(IMG_W-1)) r_row <= r_row + RW'(1);
                    r_state <= w_last ? DONE : BORDER;
                end else begin
                    r_cnt   <= '0;
                    r_state <= r_col == CW'(1) ? FILL : SHIFT;
                    if (r_col != CW'(1))
                        for (int i = 0; i < 3; i++) begin
                            r_win[3*i]   <= r_win[3*i+1];
                            r_win[3*i+1] <= r_win[3*i+2];
                        end
                end
                FILL, SHIFT: if (gray_ready) begin
                    r_win[w_wi] <= gray_data;
                    r_cnt       <= r_cnt + 4'd1;
                    if (r_cnt == (r_state == FILL ? 4'd8 : 4'd2)) r_state <= WRITE;
                end
                WRITE: begin
                    r_col   <= r_col + CW'(1);
                    r_state <= BORDER;
                end
                DONE: r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbp_param.sv
// tb_lbp_param: random and directed frames on an 8x8 image checked against a pixel-level LBP model.
module tb_lbp_param;
    localparam int W = 8, H = 8, N = W * H, AW = 6;
    localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic          clk = 0, reset = 1, gray_ready = 0, mode = 0;
    logic [7:0]    thr = 0;
    logic          gray_req, lbp_valid, finish;
    logic [7:0]    gray_data, lbp_data;
    logic [AW-1:0] gray_addr, lbp_addr;
    logic [7:0]    img [N];
    logic [7:0]    got [N];
    int            wcyc [N];
    int            checks = 0, errors = 0, req_viol = 0;

    always #5 clk = ~clk;

    lbp_param #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_addr(gray_addr),
        .gray_req(gray_req), .gray_data(gray_data), .mode(mode), .thr(thr),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish)
    );

    assign gray_data = img[gray_addr];

    function automatic logic [7:0] lbp_ref(input int idx, input bit m, input int t);
        int r = idx / W;
        int c = idx % W;
        logic [7:0] code = '0;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        for (int k = 0; k < 8; k++) begin
            int nb = int'(img[(r + DY[k]) * W + c + DX[k]]);
            code[k] = nb >= int'(img[idx]) + (m ? t : 0);
        end
        return code;
    endfunction

    task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
        checks++;
        assert (g === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, g, e);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        gray_ready = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    // stop_at >= 0 returns early once that many+1 writes were seen
    task automatic run_frame(input bit m, input int t, input bit rnd, input int stop_at);
        int n = 0;
        int cyc = 0;
        bit scramble = 0;
        mode = m;
        thr = 8'(t);
        gray_ready = 1;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (gray_req && !gray_ready) req_viol++;
            if (lbp_valid) begin
                chk("wr_addr", 32'(lbp_addr), 32'(n));
                if (n < N) begin
                    chk("wr_data", 32'(lbp_data), 32'(lbp_ref(n, m, t)));
                    got[n] = lbp_data;
                    wcyc[n] = cyc;
                end
                n++;
                scramble = 1;
                if (stop_at >= 0 && n > stop_at) return;
            end
            if (finish) break;
            gray_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (scramble) begin
                mode = 1'($urandom);
                thr = 8'($urandom);
            end
        end
        chk("finish", 32'(finish), 32'd1);
        chk("write_count", 32'(n), 32'(N));
        repeat (4) begin
            @(negedge clk);
            chk("done_hold", {29'd0, finish, lbp_valid, gray_req}, 32'b100);
        end
    endtask

    initial begin
        reset = 1;
        gray_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_gray_req", 32'(gray_req), 0);
        chk("rst_lbp_valid", 32'(lbp_valid), 0);
        chk("rst_finish", 32'(finish), 0);
        chk("rst_gray_addr", 32'(gray_addr), 0);
        chk("rst_lbp_addr", 32'(lbp_addr), 0);
        chk("rst_lbp_data", 32'(lbp_data), 0);

        for (int i = 0; i < N; i++) img[i] = 8'h40;
        reset = 0;
        run_frame(0, 0, 0, -1);
        chk("flat_interior", 32'(got[W + 1]), 32'hFF);
        chk("flat_border", 32'(got[W]), 32'h00);
        // gaps include the previous pixel's write cycle
        chk("latency_col1", 32'(wcyc[W + 1] - wcyc[W]), 32'd11);
        chk("latency_col2", 32'(wcyc[W + 2] - wcyc[W + 1]), 32'd5);
        do_reset();
        run_frame(1, 1, 0, -1);
        chk("flat_thr1", 32'(got[W + 1]), 32'h00);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        do_reset();
        run_frame(0, 0, 1, -1);
        do_reset();
        run_frame(1, $urandom_range(0, 40), 1, -1);

        for (int k = 0; k < 9; k++) img[(1 + k / 3) * W + 1 + k % 3] = 8'(k + 1);
        for (int k = 0; k < 9; k++) img[(3 + k / 3) * W + 4 + k % 3] = 8'd255;
        img[4 * W + 5] = 8'd250;
        do_reset();
        run_frame(0, 0, 1, -1);
        chk("order_window", 32'(got[2 * W + 2]), 32'hF0);
        chk("overflow_mode0", 32'(got[4 * W + 5]), 32'hFF);
        do_reset();
        run_frame(1, 10, 1, -1);
        chk("overflow_mode1", 32'(got[4 * W + 5]), 32'h00);

        for (int i = 0; i < N; i++) img[i] = 8'($urandom);
        do_reset();
        run_frame(0, 0, 1, 2 * W + 3);
        reset = 1;
        #1;
        chk("midrst_valid_now", 32'(lbp_valid), 0);
        chk("midrst_req_now", 32'(gray_req), 0);
        @(negedge clk);
        chk("midrst_valid_next", 32'(lbp_valid), 0);
        chk("midrst_lbp_addr", 32'(lbp_addr), 0);
        reset = 0;
        run_frame(0, 0, 1, -1);

        chk("req_without_ready", 32'(req_viol), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lbp_param.md
LBP_PARAM -- requirements
Module: lbp_param

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels; power of 2, minimum 4.
REQ-002 Parameter IMG_H, default 128, image height in pixels; power of 2, minimum 4.
REQ-003 Parameter DATA_W, default 8, gray and LBP sample width.
REQ-004 Parameter ADDR_W, default 14, address width; equals log2(IMG_W*IMG_H).
REQ-005 clk  in  1  sole clock; all flops on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 gray_ready  in  1  gray memory available; low stalls reads.
REQ-008 gray_addr  out  ADDR_W  read address, row*IMG_W+col.
REQ-009 gray_req  out  1  read strobe.
REQ-010 gray_data  in  DATA_W  read data.
REQ-011 mode  in  1  0: standard LBP; 1: thresholded LBP.
REQ-012 thr  in  DATA_W  threshold offset for mode 1.
REQ-013 lbp_addr  out  ADDR_W  result address.
REQ-014 lbp_valid  out  1  result write strobe.
REQ-015 lbp_data  out  8  LBP code.
REQ-016 finish  out  1  frame complete.

Function
REQ-017 gray_data shall be sampled on the rising edge ending a cycle in which gray_req=1 and gray_ready=1; zero wait states.
REQ-018 gray_req shall be 0 whenever gray_ready=0; FSM, address and window registers hold during the stall.
REQ-019 mode and thr shall be captured once, in the first cycle after reset deassertion in which gray_ready=1, and held for the frame.
REQ-020 Outputs shall be produced in raster order, addresses 0 to IMG_W*IMG_H-1, each written exactly once.
REQ-021 Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) shall be written with lbp_data=0, one per cycle, with no gray reads; border writes do not depend on gray_ready.
REQ-022 States: IDLE, BORDER, FILL, SHIFT, WRITE, DONE.
REQ-023 IDLE->BORDER when gray_ready=1; BORDER writes the current pixel if it is a border pixel, otherwise it goes to FILL (col 1) or SHIFT (col>1).
REQ-024 FILL shall read the 9 pixels of the 3x3 window in raster order, one per un-stalled cycle.
REQ-025 SHIFT shall shift the window left one column and read the 3 new right-column pixels, top to bottom.
REQ-026 WRITE shall pulse lbp_valid for exactly one cycle, in the cycle after the last window read, then return to BORDER for the next pixel.
REQ-027 Bit order: top-left=bit0, top=bit1, top-right=bit2, left=bit3, right=bit4, bottom-left=bit5, bottom=bit6, bottom-right=bit7.
REQ-028 Mode 0: bit=1 iff neighbour >= centre.
REQ-029 Mode 1: bit=1 iff neighbour >= centre+thr, with the sum computed in DATA_W+1 bits; a sum above 2^DATA_W-1 yields bit=0.
REQ-030 lbp_addr and lbp_data shall be stable while lbp_valid=1.
REQ-031 After writing address IMG_W*IMG_H-1, the FSM shall enter DONE, assert finish the next cycle, and hold finish=1 with no further gray_req or lbp_valid until reset.
REQ-032 Interior pixel latency: 10 cycles at col 1 and 4 cycles at col>1 with no stalls; each stall cycle adds one cycle.

Reset
REQ-033 Reset values: gray_req=0, lbp_valid=0, finish=0, gray_addr=0, lbp_addr=0, lbp_data=0; state=IDLE.
REQ-034 Reset asserted mid-frame shall abort the frame within one cycle; no lbp_valid in the reset cycle or after it.
REQ-035 After reset deasserts, a new frame restarts from address 0 and recaptures mode and thr.

Verification
REQ-036 IMG_W=IMG_H=4, all pixels 0x40, mode=0 -> addresses 5, 6, 9, 10 = 0xFF; the 12 border pixels = 0x00; finish after 16 writes.
REQ-037 Same image, mode=1, thr=1 -> all 16 results 0x00.
REQ-038 Centre 250 with all neighbours 255, mode=1, thr=10 -> code 0x00 (overflow case); the same window with mode=0 -> 0xFF.
REQ-039 Window with rows 1,2,3 / 4,5,6 / 7,8,9 around centre 5, mode=0 -> code 0xF0 (bits 4-7 set).
REQ-040 128x128 gray_ready toggled pseudo-randomly, mode=0 -> image matches the golden file exactly; gray_req never high while gray_ready=0.
REQ-041 Reset pulsed during row 2, then a full run -> no writes after reset; the final image matches golden; finish asserts once.
